// File: rtl/segdisp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// SEG_LUT patterns are active-high, bit order gfedcba.
package segdisp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/segdisp_scan_ctrl_if.sv
// Register-side inputs and display pins of the scan controller, plus FSM state for debug.
// Handshake: data_valid is a one-cycle strobe with no ready; data_in/dp_in are captured on every cycle it is high.
interface segdisp_scan_ctrl_if;
    import segdisp_pkg::*;

    logic [31:0] data_in;
    logic        data_valid;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic        blank_lz;
    logic        enable;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  dig_sel;
    logic        frame_done;
    state_t      state;

    modport master (
        output data_in, data_valid, dp_in, digit_en, blank_lz, enable,
        input  seg, dp, dig_sel, frame_done, state
    );

    modport slave (
        input  data_in, data_valid, dp_in, digit_en, blank_lz, enable,
        output seg, dp, dig_sel, frame_done, state
    );

endinterface

// File: rtl/segdisp_scan_ctrl_hex7seg.sv
// Combinational hex nibble to active-high gfedcba segment pattern.
module hex7seg
    import segdisp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nib];

endmodule

// File: rtl/segdisp_scan_ctrl.sv
// Eight-digit multiplexed display scanner with blank gaps, leading-zero
// blanking and frame-aligned double buffering of the display register.
module segdisp_scan_ctrl
    import segdisp_pkg::*;
#(
    parameter int ON_CYCLES      = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    segdisp_scan_ctrl_if.slave bus
);

    localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [7:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    // Reset asserts immediately but releases two clocks after reset_n rises.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    state_t        state;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic          wrap_q;
    logic [31:0]   pending_data, shadow_data;
    logic [7:0]    pending_dp, shadow_dp;
    logic          pend_flag;
    logic          boundary;
    logic [3:0]    nib;
    logic [6:0]    lut_seg;
    logic          lz_blank;

    assign boundary = bus.enable && (state == ON) && (idx == 3'd7) && (cnt == ON_LAST);
    assign nib      = 4'(shadow_data >> {idx, 2'b00});
    assign lz_blank = bus.blank_lz && (idx != 3'd0) && ((shadow_data >> {idx, 2'b00}) == 32'd0);
    assign bus.state = state;

    hex7seg u_hex7seg (
        .nib (nib),
        .seg (lut_seg)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state  <= IDLE;
            idx    <= 3'd0;
            cnt    <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= boundary;
            if (!bus.enable) begin
                state <= IDLE;
                idx   <= 3'd0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= BLANK;
                        cnt   <= '0;
                    end
                    BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            state <= ON;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ON: begin
                        if (cnt == ON_LAST) begin
                            state <= BLANK;
                            cnt   <= '0;
                            idx   <= idx + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A strobe landing on the boundary bypasses pending so it shows in the very next frame.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pending_data <= '0;
            pending_dp   <= '0;
            shadow_data  <= '0;
            shadow_dp    <= '0;
            pend_flag    <= 1'b0;
        end else if (bus.data_valid) begin
            pending_data <= bus.data_in;
            pending_dp   <= bus.dp_in;
            if (boundary) begin
                shadow_data <= bus.data_in;
                shadow_dp   <= bus.dp_in;
                pend_flag   <= 1'b0;
            end else begin
                pend_flag <= 1'b1;
            end
        end else if (pend_flag && (boundary || state == IDLE)) begin
            shadow_data <= pending_data;
            shadow_dp   <= pending_dp;
            pend_flag   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            bus.seg        <= SEG_OFF;
            bus.dp         <= DP_OFF;
            bus.dig_sel    <= DIG_OFF;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= wrap_q;
            if (state == ON) begin
                bus.seg     <= (lz_blank ? 7'd0 : lut_seg) ^ SEG_OFF;
                bus.dp      <= (lz_blank ? 1'b0 : shadow_dp[idx]) ^ DP_OFF;
                bus.dig_sel <= (bus.digit_en[idx] ? (8'd1 << idx) : 8'd0) ^ DIG_OFF;
            end else begin
                bus.seg     <= SEG_OFF;
                bus.dp      <= DP_OFF;
                bus.dig_sel <= DIG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_segdisp_scan_ctrl.sv
// Randomized bench for segdisp_scan_ctrl: a frame-position reference model
// predicts every pin each cycle, plus directed scan, buffering and blanking scenarios.
module tb_segdisp_scan_ctrl;
    import segdisp_pkg::*;

    localparam int ON_C  = 4;
    localparam int BL_C  = 2;
    localparam int SLOT  = ON_C + BL_C;
    localparam int FRAME = 8 * SLOT;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    segdisp_scan_ctrl_if bus();

    segdisp_scan_ctrl #(
        .ON_CYCLES      (ON_C),
        .BLANK_CYCLES   (BL_C),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: ref_seg = 7'h3F;  4'h1: ref_seg = 7'h06;
            4'h2: ref_seg = 7'h5B;  4'h3: ref_seg = 7'h4F;
            4'h4: ref_seg = 7'h66;  4'h5: ref_seg = 7'h6D;
            4'h6: ref_seg = 7'h7D;  4'h7: ref_seg = 7'h07;
            4'h8: ref_seg = 7'h7F;  4'h9: ref_seg = 7'h6F;
            4'hA: ref_seg = 7'h77;  4'hB: ref_seg = 7'h7C;
            4'hC: ref_seg = 7'h39;  4'hD: ref_seg = 7'h5E;
            4'hE: ref_seg = 7'h79;  default: ref_seg = 7'h71;
        endcase
    endfunction

    // Reference model: position within the frame, advanced one per clock while running.
    bit          m_run = 0;
    int          m_pos = 0;
    int          m_frames = 0;
    int          rel = 0;
    logic [31:0] m_shadow = '0, m_pend = '0;
    logic [7:0]  m_sdp = '0, m_pdp = '0;
    bit          m_pflag = 0;
    logic [16:0] exp_q[$];

    always @(posedge clk or negedge reset_n) begin : model
        int d;
        bit lz, bnd, fd;
        logic [6:0] r_seg;
        logic [7:0] r_dig;
        logic r_dp;
        if (!reset_n || rel < 2) begin
            if (!reset_n) rel = 0;
            else rel++;
            m_run = 0; m_pos = 0; m_frames = 0;
            m_shadow = '0; m_pend = '0; m_sdp = '0; m_pdp = '0; m_pflag = 0;
            exp_q.delete();
        end else begin
            r_seg = '0; r_dig = '0; r_dp = 1'b0;
            if (m_run && (m_pos % SLOT) >= BL_C) begin
                d  = m_pos / SLOT;
                lz = bus.blank_lz && d > 0 && ((m_shadow >> (4 * d)) == 32'd0);
                r_dig = bus.digit_en[d] ? 8'(1 << d) : 8'd0;
                if (!lz) begin
                    r_seg = ref_seg(m_shadow[4*d +: 4]);
                    r_dp  = m_sdp[d];
                end
            end
            fd = m_run && m_pos == 0 && m_frames > 0;
            exp_q.push_back({fd, ~r_dp, ~r_dig, ~r_seg});

            bnd = m_run && bus.enable && m_pos == FRAME - 1;
            if (bus.data_valid) begin
                m_pend = bus.data_in; m_pdp = bus.dp_in;
                if (bnd) begin m_shadow = bus.data_in; m_sdp = bus.dp_in; m_pflag = 0; end
                else m_pflag = 1;
            end else if (m_pflag && (bnd || !m_run)) begin
                m_shadow = m_pend; m_sdp = m_pdp; m_pflag = 0;
            end

            if (!bus.enable) begin m_run = 0; m_pos = 0; m_frames = 0; end
            else if (!m_run) begin m_run = 1; m_pos = 0; end
            else if (m_pos == FRAME - 1) begin m_pos = 0; m_frames++; end
            else m_pos++;
        end
    end

    // Scoreboard: every cycle's pins against the model's queued prediction.
    always @(negedge clk) begin : scoreboard
        logic [16:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b0, 1'b1, 8'hFF, 7'h7F};
        check("seg", {25'd0, bus.seg}, {25'd0, e[6:0]});
        check("dig_sel", {24'd0, bus.dig_sel}, {24'd0, e[14:7]});
        check("dp", {31'd0, bus.dp}, {31'd0, e[15]});
        check("frame_done", {31'd0, bus.frame_done}, {31'd0, e[16]});
        check("onehot", {31'd0, ($countones(~bus.dig_sel) <= 1)}, 32'd1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [31:0] d, input logic [7:0] p);
        bus.data_in = d; bus.dp_in = p; bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
    endtask

    // Returns at the negedge where the scanner sits at frame position target.
    task automatic wait_pos(input int target);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(m_run && m_pos == target) && n < 400);
        check("wait_pos", {31'd0, (m_run && m_pos == target)}, 32'd1);
    endtask

    task automatic measure_start(input string tag);
        int lat;
        bus.enable = 1'b1;
        @(negedge clk);
        lat = 0;
        do begin @(negedge clk); lat++; end while (bus.dig_sel == 8'hFF && lat < 20);
        check(tag, lat, BL_C + 1);
    endtask

    task automatic measure_frame(input string tag);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.frame_done && n < 200);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.frame_done && n < 200);
        check(tag, n, FRAME);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int fdc, hi;
        int r, k;
        bus.data_in = '0; bus.data_valid = 1'b0; bus.dp_in = '0;
        bus.digit_en = 8'hFF; bus.blank_lz = 1'b0; bus.enable = 1'b0;
        #1 reset_n = 1'b0;
        tick(3);
        check("rst_dig", {24'd0, bus.dig_sel}, 32'hFF);
        check("rst_seg", {25'd0, bus.seg}, 32'h7F);
        reset_n = 1'b1;
        tick(6);
        check("idle_dig", {24'd0, bus.dig_sel}, 32'hFF);
        check("idle_state", {30'd0, bus.state}, {30'd0, IDLE});

        // Basic scan
        write_reg(32'h7654_3210, 8'h00);
        tick(2);
        measure_start("first_dig_lat");
        check("d0_seg", {25'd0, bus.seg}, 32'h40);
        check("d0_dig", {24'd0, bus.dig_sel}, 32'hFE);
        tick(SLOT);
        check("d1_seg", {25'd0, bus.seg}, 32'h79);
        check("d1_dig", {24'd0, bus.dig_sel}, 32'hFD);
        measure_frame("fd_period");

        // Double buffering
        write_reg(32'h0, 8'h00);
        wait_pos(0);
        wait_pos(3 * SLOT + BL_C);
        write_reg(32'hFFFF_FFFF, 8'h00);
        wait_pos(4 * SLOT + BL_C); tick(1);
        check("dbuf_old_d4", {25'd0, bus.seg}, 32'h40);
        wait_pos(7 * SLOT + BL_C); tick(1);
        check("dbuf_old_d7", {25'd0, bus.seg}, 32'h40);
        wait_pos(BL_C); tick(1);
        check("dbuf_new_d0", {25'd0, bus.seg}, 32'h0E);
        wait_pos(FRAME - 1);
        write_reg(32'h1111_1111, 8'h00);
        wait_pos(BL_C); tick(1);
        check("bnd_d0", {25'd0, bus.seg}, 32'h79);

        // Leading-zero blanking
        bus.blank_lz = 1'b1;
        write_reg(32'h0000_0A05, 8'hFF);
        wait_pos(0);
        wait_pos(BL_C); tick(1);
        check("lz_d0", {25'd0, bus.seg}, 32'h12);
        wait_pos(SLOT + BL_C); tick(1);
        check("lz_d1", {25'd0, bus.seg}, 32'h40);
        wait_pos(2 * SLOT + BL_C); tick(1);
        check("lz_d2", {25'd0, bus.seg}, 32'h08);
        wait_pos(3 * SLOT + BL_C); tick(1);
        check("lz_d3_seg", {25'd0, bus.seg}, 32'h7F);
        check("lz_d3_dp", {31'd0, bus.dp}, 32'd1);
        check("lz_d3_dig", {24'd0, bus.dig_sel}, 32'hF7);
        write_reg(32'h0, 8'h00);
        wait_pos(0);
        wait_pos(BL_C); tick(1);
        check("lz0_d0", {25'd0, bus.seg}, 32'h40);
        wait_pos(SLOT + BL_C); tick(1);
        check("lz0_d1", {25'd0, bus.seg}, 32'h7F);

        // Per-digit enable
        bus.blank_lz = 1'b0;
        bus.digit_en = 8'h0F;
        write_reg(32'h89AB_CDEF, 8'h5A);
        wait_pos(0);
        hi = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (bus.dig_sel[7:4] != 4'hF) hi++;
        end
        check("den_hi_never", hi, 0);
        measure_frame("den_fd_period");

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                k = $urandom_range(0, 7);
                write_reg($urandom >> (4 * k), 8'($urandom));
            end else if (r == 4) begin
                bus.digit_en = 8'($urandom);
            end else if (r == 5) begin
                bus.blank_lz = 1'($urandom_range(0, 1));
            end else if (r == 6) begin
                bus.enable = 1'b0;
                tick($urandom_range(1, 8));
                bus.enable = 1'b1;
            end else begin
                tick($urandom_range(1, 30));
            end
        end

        // Disable mid-frame
        bus.enable = 1'b1;
        bus.digit_en = 8'hFF;
        bus.blank_lz = 1'b0;
        wait_pos(5 * SLOT + BL_C + 1);
        bus.enable = 1'b0;
        @(negedge clk);
        check("dis_state", {30'd0, bus.state}, {30'd0, IDLE});
        fdc = bus.frame_done;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            fdc += bus.frame_done;
        end
        check("dis_no_fd", fdc, 0);
        check("dis_dark", {24'd0, bus.dig_sel}, 32'hFF);
        measure_start("reen_lat");
        check("reen_d0", {24'd0, bus.dig_sel}, 32'hFE);

        // Asynchronous reset while a digit is lit
        k = 0;
        while (bus.dig_sel == 8'hFF && k < 100) begin @(negedge clk); k++; end
        check("pre_rst_lit", {31'd0, (bus.dig_sel != 8'hFF)}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_dig", {24'd0, bus.dig_sel}, 32'hFF);
        check("async_rst_seg", {25'd0, bus.seg}, 32'h7F);
        check("async_rst_dp", {31'd0, bus.dp}, 32'd1);
        bus.enable = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(6);
        check("post_rst_dig", {24'd0, bus.dig_sel}, 32'hFF);
        check("post_rst_state", {30'd0, bus.state}, {30'd0, IDLE});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
